// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the arbiter, its host/CPU clients and the shared SRAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 32
);
   logic              start;
   logic              halt;

   logic              h_req;
   logic              h_we;
   logic [31:0]       h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_ack;
   logic              h_rvalid;
   logic [DATA_W-1:0] h_rdata;

   logic              i_req;
   logic [31:0]       i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              d_re;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              cpu_stall;
   logic              cpu_hold;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  start, halt,
      input  h_req, h_we, h_addr, h_wdata,
      output h_ack, h_rvalid, h_rdata,
      input  i_req, i_addr, d_re, d_we, d_addr, d_wdata,
      output i_rdata, d_rdata, cpu_stall, cpu_hold,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output start, halt,
      output h_req, h_we, h_addr, h_wdata,
      input  h_ack, h_rvalid, h_rdata,
      output i_req, i_addr, d_re, d_we, d_addr, d_wdata,
      input  i_rdata, d_rdata, cpu_stall, cpu_hold,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Boot sequencer and single-port SRAM arbiter: host owns the memory in BOOT,
// CPU fetch and load/store share it in RUN with a pipeline stall until served.
module cpu_mem_arbiter #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   cpu_mem_arbiter_if.slave bus
);
   localparam logic [0:0] BOOT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_I    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_H    = 2'd3;

   logic [0:0]        state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic              i_done_q, d_done_q;
   logic              i_held_q, d_held_q;
   logic              halt_pend_q;
   logic [DATA_W-1:0] i_hold_q, d_hold_q;

   logic in_run;
   logic grant_h, grant_i, grant_d;
   logic i_ready, d_ready;
   logic stall, advance;
   logic halt_seen, go_boot, go_run;
   logic unused_addr_bits;

   // Only word-address bits reach the SRAM; byte offset and alias bits are dropped.
   assign unused_addr_bits = ^{bus.h_addr[1:0], bus.h_addr[31:ADDR_W+2],
                               bus.i_addr[1:0], bus.i_addr[31:ADDR_W+2],
                               bus.d_addr[1:0], bus.d_addr[31:ADDR_W+2]};

   assign in_run  = (state_q == RUN);
   assign grant_h = !in_run && bus.h_req;
   assign grant_d = in_run && (bus.d_re || bus.d_we) && !d_done_q;
   assign grant_i = in_run && bus.i_req && !i_done_q && !grant_d;

   assign i_ready = (owner_q == OWN_I) || i_held_q;
   assign d_ready = (owner_q == OWN_D) || d_held_q;

   assign stall   = !in_run
                 || (bus.i_req && !i_ready)
                 || (bus.d_re  && !d_ready)
                 || (bus.d_we  && !(d_done_q || grant_d));
   assign advance = !stall;

   // Leave RUN only when nothing new launches and the served flags will clear.
   assign halt_seen = in_run && (bus.halt || halt_pend_q);
   assign go_boot   = halt_seen && !grant_d && !grant_i
                   && (advance || !(i_done_q || d_done_q));
   assign go_run    = !in_run && bus.start;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      owner_d       = OWN_NONE;
      if (grant_h) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.h_we;
         bus.mem_addr  = bus.h_addr[ADDR_W+1:2];
         bus.mem_wdata = bus.h_wdata;
         owner_d       = bus.h_we ? OWN_NONE : OWN_H;
      end else if (grant_d) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.d_we;
         bus.mem_addr  = bus.d_addr[ADDR_W+1:2];
         bus.mem_wdata = bus.d_we ? bus.d_wdata : '0;
         owner_d       = bus.d_re ? OWN_D : OWN_NONE;
      end else if (grant_i) begin
         bus.mem_en    = 1'b1;
         bus.mem_addr  = bus.i_addr[ADDR_W+1:2];
         owner_d       = OWN_I;
      end
   end

   always_comb begin
      state_d = state_q;
      if (go_run)  state_d = RUN;
      if (go_boot) state_d = BOOT;
   end

   assign bus.h_ack     = grant_h;
   assign bus.h_rvalid  = (owner_q == OWN_H);
   assign bus.h_rdata   = bus.h_rvalid ? bus.mem_rdata : '0;
   assign bus.i_rdata   = (owner_q == OWN_I) ? bus.mem_rdata : i_hold_q;
   assign bus.d_rdata   = (owner_q == OWN_D) ? bus.mem_rdata : d_hold_q;
   assign bus.cpu_stall = stall;
   assign bus.cpu_hold  = !in_run;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         owner_q     <= OWN_NONE;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         i_held_q    <= 1'b0;
         d_held_q    <= 1'b0;
         halt_pend_q <= 1'b0;
         i_hold_q    <= '0;
         d_hold_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;

         if (in_run && !go_boot && !advance) begin
            i_done_q <= i_done_q || grant_i;
            d_done_q <= d_done_q || grant_d;
            i_held_q <= i_held_q || (owner_q == OWN_I);
            d_held_q <= d_held_q || (owner_q == OWN_D);
         end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            i_held_q <= 1'b0;
            d_held_q <= 1'b0;
         end

         halt_pend_q <= halt_seen && !go_boot;

         if (owner_q == OWN_I) i_hold_q <= bus.mem_rdata;
         if (owner_q == OWN_D) d_hold_q <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: boot loading, RUN arbitration, halt
// deferral, start/halt collision and reset during a pending return.
module tb_cpu_mem_arbiter;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] sram [256];
   logic [31:0] sram_q = '0;
   int          n_checks = 0;
   int          n_pass = 0;

   cpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   cpu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read, read-first SRAM model.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) sram[bus.mem_addr[7:0]] <= bus.mem_wdata;
         sram_q <= sram[bus.mem_addr[7:0]];
      end
   end
   assign bus.mem_rdata = sram_q;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 0; bus.halt = 0;
      bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_re = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL rst_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL rst_stall: got %b want 1", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); else n_pass++;
      n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); else n_pass++;
      n_checks++; if (bus.mem_addr !== 19'h0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); else n_pass++;
      n_checks++; if (bus.h_ack !== 1'b0) $display("FAIL rst_h_ack: got %b want 0", bus.h_ack); else n_pass++;
      n_checks++; if (bus.h_rvalid !== 1'b0) $display("FAIL rst_h_rvalid: got %b want 0", bus.h_rvalid); else n_pass++;
      n_checks++; if (bus.h_rdata !== 32'h0) $display("FAIL rst_h_rdata: got %h want 0", bus.h_rdata); else n_pass++;
      n_checks++; if (bus.i_rdata !== 32'h0) $display("FAIL rst_i_rdata: got %h want 0", bus.i_rdata); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'h0) $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); else n_pass++;
      rst_n = 1;
      step();
      step();
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL rst_no_start_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      step();
   endtask

   task automatic test_boot_load();
      bus.h_req = 1; bus.h_we = 1; bus.h_addr = 32'h0; bus.h_wdata = 32'h0040_0093;
      @(negedge clk);
      n_checks++; if (bus.h_ack !== 1'b1) $display("FAIL boot_wr_ack: got %b want 1", bus.h_ack); else n_pass++;
      n_checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) $display("FAIL boot_wr_en_we: got %b want 11", {bus.mem_en, bus.mem_we}); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 32'h0040_0093) $display("FAIL boot_wr_wdata: got %h want 00400093", bus.mem_wdata); else n_pass++;
      step();
      bus.h_addr = 32'h4; bus.h_wdata = 32'd100;
      @(negedge clk);
      n_checks++; if (bus.h_rvalid !== 1'b0) $display("FAIL boot_wr_no_rvalid: got %b want 0", bus.h_rvalid); else n_pass++;
      n_checks++; if (bus.mem_addr !== 19'h1) $display("FAIL boot_wr_addr: got %h want 1", bus.mem_addr); else n_pass++;
      step();
      bus.h_addr = 32'h8; bus.h_wdata = 32'h55;
      step();
      bus.h_we = 0; bus.h_addr = 32'h0;
      @(negedge clk);
      n_checks++; if ({bus.h_ack, bus.mem_we} !== 2'b10) $display("FAIL boot_rd_ack_we: got %b want 10", {bus.h_ack, bus.mem_we}); else n_pass++;
      step();
      bus.h_req = 0;
      @(negedge clk);
      n_checks++; if (bus.h_rvalid !== 1'b1) $display("FAIL boot_rd_rvalid: got %b want 1", bus.h_rvalid); else n_pass++;
      n_checks++; if (bus.h_rdata !== 32'h0040_0093) $display("FAIL boot_rd_data: got %h want 00400093", bus.h_rdata); else n_pass++;
      n_checks++; if (bus.h_ack !== 1'b0) $display("FAIL boot_idle_ack: got %b want 0", bus.h_ack); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.h_rvalid !== 1'b0) $display("FAIL boot_rvalid_drop: got %b want 0", bus.h_rvalid); else n_pass++;
      step();
   endtask

   task automatic test_fetch_load();
      bus.start = 1;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL start_pre_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      step();
      bus.start = 0;
      bus.i_req = 1; bus.i_addr = 32'h0; bus.d_re = 1; bus.d_addr = 32'h4;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL fl_hold: got %b want 0", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL fl_stall_t0: got %b want 1", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.mem_addr !== 19'h1) $display("FAIL fl_d_first: got %h want 1", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.h_ack !== 1'b0) $display("FAIL fl_no_h_ack: got %b want 0", bus.h_ack); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL fl_stall_t1: got %b want 1", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.mem_addr !== 19'h0) $display("FAIL fl_i_second: got %h want 0", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'd100) $display("FAIL fl_d_return: got %h want 64", bus.d_rdata); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL fl_stall_t2: got %b want 0", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.i_rdata !== 32'h0040_0093) $display("FAIL fl_i_return: got %h want 00400093", bus.i_rdata); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'd100) $display("FAIL fl_d_held: got %h want 64", bus.d_rdata); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL fl_no_regrant: got %b want 0", bus.mem_en); else n_pass++;
      step();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (bus.i_rdata !== 32'h0040_0093) $display("FAIL fl_i_hold_reg: got %h want 00400093", bus.i_rdata); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'd100) $display("FAIL fl_d_hold_reg: got %h want 64", bus.d_rdata); else n_pass++;
      step();
   endtask

   task automatic test_store_fetch();
      bus.d_we = 1; bus.d_addr = 32'h8; bus.d_wdata = 32'd7; bus.i_req = 1; bus.i_addr = 32'h4;
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL sf_stall_t0: got %b want 1", bus.cpu_stall); else n_pass++;
      n_checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b1, 19'h2}) $display("FAIL sf_store_grant: got %b/%h want 1/2", bus.mem_we, bus.mem_addr); else n_pass++;
      n_checks++; if (bus.mem_wdata !== 32'd7) $display("FAIL sf_wdata: got %h want 7", bus.mem_wdata); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (sram[2] !== 32'd7) $display("FAIL sf_mem2: got %h want 7", sram[2]); else n_pass++;
      n_checks++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, 19'h1}) $display("FAIL sf_fetch_grant: got %b/%h want 0/1", bus.mem_we, bus.mem_addr); else n_pass++;
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL sf_stall_t1: got %b want 1", bus.cpu_stall); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL sf_stall_t2: got %b want 0", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.i_rdata !== 32'd100) $display("FAIL sf_i_return: got %h want 64", bus.i_rdata); else n_pass++;
      step();
      clear_inputs();
   endtask

   task automatic test_fetch_only();
      bus.i_req = 1; bus.i_addr = 32'h8;
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b1) $display("FAIL fo_stall_t0: got %b want 1", bus.cpu_stall); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL fo_stall_t1: got %b want 0", bus.cpu_stall); else n_pass++;
      n_checks++; if (bus.i_rdata !== 32'd7) $display("FAIL fo_i_return: got %h want 7", bus.i_rdata); else n_pass++;
      step();
      clear_inputs();
   endtask

   task automatic test_store_only();
      bus.d_we = 1; bus.d_addr = 32'hC; bus.d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL so_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b11, 19'h3}) $display("FAIL so_grant: got %b%b/%h want 11/3", bus.mem_en, bus.mem_we, bus.mem_addr); else n_pass++;
      step();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (sram[3] !== 32'hDEAD_BEEF) $display("FAIL so_mem3: got %h want deadbeef", sram[3]); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL so_idle_en: got %b want 0", bus.mem_en); else n_pass++;
      step();
   endtask

   task automatic test_alias();
      bus.i_req = 1; bus.i_addr = 32'h0020_0000;
      @(negedge clk);
      n_checks++; if (bus.mem_addr !== 19'h0) $display("FAIL alias_addr: got %h want 0", bus.mem_addr); else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if (bus.i_rdata !== 32'h0040_0093) $display("FAIL alias_data: got %h want 00400093", bus.i_rdata); else n_pass++;
      step();
      clear_inputs();
   endtask

   task automatic test_halt_inflight();
      bus.d_re = 1; bus.d_addr = 32'hC; bus.halt = 1;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL hi_hold_t0: got %b want 0", bus.cpu_hold); else n_pass++;
      step();
      bus.halt = 0;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL hi_hold_t1: got %b want 0", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) $display("FAIL hi_load_data: got %h want deadbeef", bus.d_rdata); else n_pass++;
      n_checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL hi_stall_t1: got %b want 0", bus.cpu_stall); else n_pass++;
      step();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL hi_hold_t2: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) $display("FAIL hi_d_kept: got %h want deadbeef", bus.d_rdata); else n_pass++;
      step();
   endtask

   task automatic test_start_halt();
      bus.start = 1; bus.halt = 1;
      step();
      bus.start = 0; bus.halt = 0;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL sh_boot_start_wins: got %b want 0", bus.cpu_hold); else n_pass++;
      bus.start = 1; bus.halt = 1;
      step();
      bus.start = 0; bus.halt = 0;
      @(negedge clk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL sh_run_halt_wins: got %b want 1", bus.cpu_hold); else n_pass++;
      step();
   endtask

   task automatic test_reset_midread();
      bus.start = 1;
      step();
      bus.start = 0;
      bus.i_req = 1; bus.i_addr = 32'h8;
      @(negedge clk);
      n_checks++; if ({bus.cpu_stall, bus.mem_addr} !== {1'b1, 19'h2}) $display("FAIL rm_grant: got %b/%h want 1/2", bus.cpu_stall, bus.mem_addr); else n_pass++;
      step();
      rst_n = 0;
      clear_inputs();
      @(negedge clk);
      n_checks++; if (bus.i_rdata !== 32'h0) $display("FAIL rm_i_dropped: got %h want 0", bus.i_rdata); else n_pass++;
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL rm_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL rm_mem_en: got %b want 0", bus.mem_en); else n_pass++;
      step();
      rst_n = 1;
      step();
      @(negedge clk);
      n_checks++; if ({bus.i_rdata, bus.h_rvalid, bus.cpu_hold} !== {32'h0, 1'b0, 1'b1}) $display("FAIL rm_after: got %h/%b/%b want 0/0/1", bus.i_rdata, bus.h_rvalid, bus.cpu_hold); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sram[i] = '0;
      clear_inputs();
      test_reset();
      test_boot_load();
      test_fetch_load();
      test_store_fetch();
      test_fetch_only();
      test_store_only();
      test_alias();
      test_halt_inflight();
      test_start_halt();
      test_reset_midread();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
